// File: rtl/dance_pkg.sv
// Shared definitions for the dance scheduler.
// Holds the pattern-mode encodings understood by the LED pattern engine,
// the auto-mode FSM state type, the LED count, and small helpers that map
// a state to its successor and to the mode it drives.
package dance_pkg;

  localparam logic [1:0] MODE_R2L    = 2'd0;
  localparam logic [1:0] MODE_L2R    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam int LED_COUNT = 18;

  typedef enum logic [1:0] {
    S_R2L    = 2'd0,
    S_L2R    = 2'd1,
    S_BOUNCE = 2'd2
  } state_t;

  // Auto-mode pattern rotation: R2L -> L2R -> BOUNCE -> R2L.
  function automatic state_t next_state(input state_t s);
    state_t n;
    case (s)
      S_R2L:    n = S_L2R;
      S_L2R:    n = S_BOUNCE;
      S_BOUNCE: n = S_R2L;
      default:  n = S_R2L;
    endcase
    return n;
  endfunction

  // Mode command driven to the engine while in a given auto state.
  function automatic logic [1:0] state_mode(input state_t s);
    logic [1:0] m;
    case (s)
      S_R2L:    m = MODE_R2L;
      S_L2R:    m = MODE_L2R;
      S_BOUNCE: m = MODE_BOUNCE;
      default:  m = MODE_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dance_tick.sv
// Step-rate prescaler for the dance scheduler.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - synchronous active-high reset
//   enable - count while high; low holds the count and silences tick
//   speed  - rate select, period = TICK_DIV >> speed cycles
//   tick   - registered one-cycle strobe, once per period
module dance_tick #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [23:0] DIV = 24'(TICK_DIV);

  logic [23:0] count_r;
  logic [23:0] limit_s;

  // Terminal count for the selected speed.
  always_comb begin
    limit_s = (DIV >> speed) - 24'd1;
  end

  // Free-running counter; the >= compare lets a speed change that lowers the
  // limit below the current count fire exactly one tick on the next edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= 24'd0;
      tick    <= 1'b0;
    end else if (!enable) begin
      tick    <= 1'b0;
    end else if (count_r >= limit_s) begin
      count_r <= 24'd0;
      tick    <= 1'b1;
    end else begin
      count_r <= count_r + 24'd1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/dance_scheduler.sv
// Pattern scheduler for the LED dance engine.
// Generates the step strobe and the pattern command; in auto mode rotates
// through R2L, L2R and BOUNCE, changing only when the sweep is back at
// position 0 after DWELL_STEPS steps.
// Ports:
//   Clock        - system clock, rising edge
//   Reset        - synchronous active-high reset
//   SW[3]        - 1 auto, 0 manual
//   SW[2]        - pause
//   SW[1:0]      - manual pattern select
//   speed        - step period = TICK_DIV >> speed
//   pos_in       - engine position feedback, 0..17 (others count as nonzero)
//   mode         - pattern command to the engine (registered)
//   step_en      - one-cycle step strobe (registered)
//   pattern_done - one-cycle pulse on an auto pattern change (registered)
module dance_scheduler
  import dance_pkg::*;
#(
  parameter int TICK_DIV    = 12_500_000,
  parameter int DWELL_STEPS = 36
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] SW,
  input  logic [1:0] speed,
  input  logic [4:0] pos_in,
  output logic [1:0] mode,
  output logic       step_en,
  output logic       pattern_done
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_STEPS - 1);

  logic   auto_s;
  logic   pause_s;
  logic   at_home_s;
  state_t next_s;
  state_t state_r;
  logic [7:0] dwell_r;
  logic   auto_r;

  // Decode switches and the next auto pattern.
  always_comb begin
    auto_s    = SW[3];
    pause_s   = SW[2];
    at_home_s = (pos_in == 5'd0);
    next_s    = next_state(state_r);
  end

  dance_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (~pause_s),
    .speed  (speed),
    .tick   (step_en)
  );

  // Mode selection, auto FSM and dwell counter. Entering auto always restarts
  // at R2L with an empty dwell; leaving auto simply follows the switches.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= S_R2L;
      dwell_r      <= 8'd0;
      auto_r       <= 1'b0;
      mode         <= MODE_HOLD;
      pattern_done <= 1'b0;
    end else begin
      auto_r       <= auto_s;
      pattern_done <= 1'b0;
      if (!auto_s) begin
        mode <= SW[1:0];
      end else if (!auto_r) begin
        state_r <= S_R2L;
        dwell_r <= 8'd0;
        mode    <= MODE_R2L;
      end else if (!pause_s && step_en) begin
        if (dwell_r == DWELL_LAST) begin
          // Saturated: wait for the sweep to return home before switching.
          if (at_home_s) begin
            state_r      <= next_s;
            dwell_r      <= 8'd0;
            mode         <= state_mode(next_s);
            pattern_done <= 1'b1;
          end
        end else begin
          dwell_r <= dwell_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dance_scheduler.sv
// Directed self-checking bench for dance_scheduler (TICK_DIV=8, DWELL_STEPS=4).
module tb_dance_scheduler;

  logic       Clock;
  logic       Reset;
  logic [3:0] SW;
  logic [1:0] speed;
  logic [4:0] pos_in;
  logic [1:0] mode;
  logic       step_en;
  logic       pattern_done;

  int tests_run;
  int tests_failed;

  dance_scheduler #(
    .TICK_DIV    (8),
    .DWELL_STEPS (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .SW           (SW),
    .speed        (speed),
    .pos_in       (pos_in),
    .mode         (mode),
    .step_en      (step_en),
    .pattern_done (pattern_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  // Edges until step_en is seen high; n is the number of edges taken.
  task automatic wait_step(input int max_edges, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step_en && n < max_edges);
    if (!step_en) check_eq("step_timeout", 32'd0, 32'd1);
  endtask

  // Strobes (each followed by its processing edge) until pattern_done.
  task automatic strobes_to_done(input int max_strobes, output int k);
    int n;
    k = 0;
    do begin
      wait_step(40, n);
      cycle();
      k++;
    end while (!pattern_done && k < max_strobes);
  endtask

  initial begin
    int n;
    int k;
    int bad;
    tests_run    = 0;
    tests_failed = 0;
    Reset  = 1'b1;
    SW     = 4'b0000;
    speed  = 2'd0;
    pos_in = 5'd0;

    // Reset state
    repeat (3) cycle();
    check_eq("rst_mode", 32'(mode), 32'd3);
    check_eq("rst_step", 32'(step_en), 32'd0);
    check_eq("rst_done", 32'(pattern_done), 32'd0);

    // Release: mode follows SW after one edge, first strobe on the 8th edge
    Reset = 1'b0;
    cycle();
    check_eq("rel_mode", 32'(mode), 32'd0);
    wait_step(40, n);
    check_eq("first_step", n, 7);
    wait_step(40, n);
    check_eq("gap_speed0", n, 8);

    // speed 2 -> period 2
    speed = 2'd2;
    wait_step(40, n);
    check_eq("gap_speed2_a", n, 2);
    wait_step(40, n);
    check_eq("gap_speed2_b", n, 2);

    // speed 0 up to count 5, then speed 3: strobe next edge, then every edge
    speed = 2'd0;
    repeat (5) cycle();
    check_eq("no_step_cnt5", 32'(step_en), 32'd0);
    speed = 2'd3;
    wait_step(40, n);
    check_eq("speed_jump", n, 1);
    wait_step(40, n);
    check_eq("gap_speed3", n, 1);

    // Manual hold and manual bounce
    SW = 4'b0011;
    cycle();
    check_eq("man_hold", 32'(mode), 32'd3);
    wait_step(40, n);
    check_eq("hold_steps", n, 1);
    SW = 4'b0010;
    cycle();
    check_eq("man_bounce", 32'(mode), 32'd2);
    check_eq("man_done", 32'(pattern_done), 32'd0);

    // Auto rotation with pos_in held at 0, speed 1 (period 4)
    SW    = 4'b1000;
    speed = 2'd1;
    cycle();
    check_eq("auto_entry", 32'(mode), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      wait_step(40, n);
      cycle();
      check_eq("auto_mode", 32'(mode), 32'((i / 4) % 3));
      check_eq("auto_done", 32'(pattern_done), (i % 4 == 0) ? 32'd1 : 32'd0);
      cycle();
      check_eq("done_width", 32'(pattern_done), 32'd0);
    end

    // Saturate dwell, then stall away from home for 3 strobes
    for (int i = 0; i < 3; i++) begin
      wait_step(40, n);
      cycle();
    end
    check_eq("sat_mode", 32'(mode), 32'd0);
    for (int i = 0; i < 3; i++) begin
      pos_in = (i == 1) ? 5'd20 : 5'd7;
      wait_step(40, n);
      cycle();
      check_eq("stall_mode", 32'(mode), 32'd0);
      check_eq("stall_done", 32'(pattern_done), 32'd0);
    end
    pos_in = 5'd0;
    wait_step(40, n);
    cycle();
    check_eq("home_mode", 32'(mode), 32'd1);
    check_eq("home_done", 32'(pattern_done), 32'd1);

    // Pause at count 3 (speed 0) for 20 cycles; dwell is 0 in L2R
    speed = 2'd0;
    repeat (2) cycle();
    SW  = 4'b1100;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (step_en || pattern_done || mode != 2'd1) bad++;
    end
    check_eq("pause_quiet", bad, 0);
    SW = 4'b1000;
    wait_step(40, n);
    check_eq("pause_resume", n, 5);
    cycle();
    strobes_to_done(10, k);
    check_eq("dwell_held", k, 3);
    check_eq("bounce_mode", 32'(mode), 32'd2);

    // Reset with a pending transition in BOUNCE
    pos_in = 5'd7;
    for (int i = 0; i < 3; i++) begin
      wait_step(40, n);
      cycle();
    end
    check_eq("pend_mode", 32'(mode), 32'd2);
    Reset = 1'b1;
    cycle();
    check_eq("mid_rst_mode", 32'(mode), 32'd3);
    check_eq("mid_rst_step", 32'(step_en), 32'd0);
    check_eq("mid_rst_done", 32'(pattern_done), 32'd0);
    Reset = 1'b0;
    cycle();
    check_eq("post_rst_mode", 32'(mode), 32'd0);
    pos_in = 5'd0;
    speed  = 2'd1;
    strobes_to_done(10, k);
    check_eq("post_rst_dwell", k, 4);
    check_eq("post_rst_next", 32'(mode), 32'd1);

    // Auto to manual: follow SW immediately, no pattern_done
    SW    = 4'b0010;
    speed = 2'd3;
    cycle();
    check_eq("to_manual", 32'(mode), 32'd2);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (pattern_done) bad++;
    end
    check_eq("manual_no_done", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
